control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/cu_opdecode.sv | 37 +++
 rtl/control_unit.sv | 180 ++++++++++++++++++
 tb/tb_control_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, control-unit state encoding,
// instruction classes and ALU strobe selection.
package cpu_pkg;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShl  = 5'b01000;
  localparam logic [4:0] OpRor  = 5'b01001;
  localparam logic [4:0] OpRol  = 5'b01010;
  localparam logic [4:0] OpAddi = 5'b01011;
  localparam logic [4:0] OpAndi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01101;
  localparam logic [4:0] OpNeg  = 5'b10000;
  localparam logic [4:0] OpNot  = 5'b10001;
  localparam logic [4:0] OpNop  = 5'b11000;
  localparam logic [4:0] OpHalt = 5'b11001;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } cu_state_e;

  typedef enum logic [2:0] {
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsRType,
    ClsImm,
    ClsUnary,
    ClsNop,
    ClsHalt
  } op_class_e;

  typedef enum logic [3:0] {
    AluNone,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluShr,
    AluShl,
    AluRor,
    AluRol,
    AluNeg,
    AluNot
  } alu_op_e;

endpackage

// File: rtl/cu_opdecode.sv
// Combinational opcode classifier: instruction class and the single ALU
// strobe the instruction uses during its compute step.
module cu_opdecode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output alu_op_e    alu_op
);

  // Map each opcode to its class and ALU operation; unknown opcodes act as nop.
  always_comb begin
    op_class = ClsNop;
    alu_op   = AluNone;
    case (opcode)
      OpLd:   begin op_class = ClsLd;    alu_op = AluAdd; end
      OpLdi:  begin op_class = ClsLdi;   alu_op = AluAdd; end
      OpSt:   begin op_class = ClsSt;    alu_op = AluAdd; end
      OpAdd:  begin op_class = ClsRType; alu_op = AluAdd; end
      OpSub:  begin op_class = ClsRType; alu_op = AluSub; end
      OpAnd:  begin op_class = ClsRType; alu_op = AluAnd; end
      OpOr:   begin op_class = ClsRType; alu_op = AluOr;  end
      OpShr:  begin op_class = ClsRType; alu_op = AluShr; end
      OpShl:  begin op_class = ClsRType; alu_op = AluShl; end
      OpRor:  begin op_class = ClsRType; alu_op = AluRor; end
      OpRol:  begin op_class = ClsRType; alu_op = AluRol; end
      OpAddi: begin op_class = ClsImm;   alu_op = AluAdd; end
      OpAndi: begin op_class = ClsImm;   alu_op = AluAnd; end
      OpOri:  begin op_class = ClsImm;   alu_op = AluOr;  end
      OpNeg:  begin op_class = ClsUnary; alu_op = AluNeg; end
      OpNot:  begin op_class = ClsUnary; alu_op = AluNot; end
      OpHalt: begin op_class = ClsHalt;  alu_op = AluNone; end
      default: begin op_class = ClsNop;  alu_op = AluNone; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit sequencing fetch and execute steps for the datapath.
// Optional feature macro CU_MEM_WAIT_EN: memory steps wait for mem_ready.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        Write,
  output logic        Run
);

  cu_state_e state_q, state_d;
  op_class_e op_class;
  alu_op_e   alu_op;
  logic      alu_en;
  logic      mem_go;
  logic      unused_ir;

  // Only the opcode field steers sequencing; operand fields go to the datapath.
  assign unused_ir = ^IR[26:0];

`ifdef CU_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  cu_opdecode u_opdecode (
    .opcode   (IR[31:27]),
    .op_class (op_class),
    .alu_op   (alu_op)
  );

  // Next-state selection; memory steps hold until mem_go.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = mem_go ? StT2 : StT1;
      StT2:    state_d = StT3;
      StT3: begin
        case (op_class)
          ClsNop:  state_d = StT0;
          ClsHalt: state_d = StHalt;
          default: state_d = StT4;
        endcase
      end
      StT4:    state_d = (op_class == ClsUnary) ? StT0 : StT5;
      StT5:    state_d = (op_class == ClsLd || op_class == ClsSt) ? StT6 : StT0;
      StT6: begin
        if (op_class == ClsLd) state_d = mem_go ? StT7 : StT6;
        else                   state_d = StT7;
      end
      StT7: begin
        if (op_class == ClsSt) state_d = mem_go ? StT0 : StT7;
        else                   state_d = StT0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clear) state_q <= StReset;
    else        state_q <= state_d;
  end

  // Datapath controls decoded from the registered state. Decoding is done from
  // state_q rather than pre-registered so the IR loaded at the end of T2 is
  // already visible in T3.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Cout    = 1'b0;
    BAout   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    alu_en  = 1'b0;
    case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      StT1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        case (op_class)
          ClsRType, ClsImm:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsLd, ClsLdi, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsUnary:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        case (op_class)
          ClsRType: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
          ClsImm, ClsLd, ClsLdi, ClsSt: begin Cout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
          ClsUnary: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        case (op_class)
          ClsRType, ClsImm, ClsLdi: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsLd, ClsSt:             begin Zlowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      StT6: begin
        if (op_class == ClsLd)      begin Read = 1'b1; MDRin = 1'b1; end
        else if (op_class == ClsSt) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      StT7: begin
        if (op_class == ClsLd)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op_class == ClsSt) Write = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU strobes: the decoder selects exactly one operation, gated by the step.
  always_comb begin
    ADD = alu_en && (alu_op == AluAdd);
    SUB = alu_en && (alu_op == AluSub);
    AND = alu_en && (alu_op == AluAnd);
    OR  = alu_en && (alu_op == AluOr);
    SHR = alu_en && (alu_op == AluShr);
    SHL = alu_en && (alu_op == AluShl);
    ROR = alu_en && (alu_op == AluRor);
    ROL = alu_en && (alu_op == AluRol);
    NEG = alu_en && (alu_op == AluNeg);
    NOT = alu_en && (alu_op == AluNot);
    Run = (state_q != StReset) && (state_q != StHalt);
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction microstep tables
// compared cycle by cycle against the DUT outputs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR = 32'h0;

  logic PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read;
  logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, Write, Run;

  control_unit dut (
    .clk(clk), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC),
    .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .Write(Write), .Run(Run)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin,
                Gra, Grb, Grc, Rin, Rout, IncPC, Read, ADD, SUB, AND, OR, SHR, SHL,
                ROR, ROL, NEG, NOT, Write, Run};

  localparam logic [29:0] M_PCOUT   = 30'h1 << 29;
  localparam logic [29:0] M_ZLOWOUT = 30'h1 << 28;
  localparam logic [29:0] M_MDROUT  = 30'h1 << 27;
  localparam logic [29:0] M_COUT    = 30'h1 << 26;
  localparam logic [29:0] M_BAOUT   = 30'h1 << 25;
  localparam logic [29:0] M_MARIN   = 30'h1 << 24;
  localparam logic [29:0] M_ZIN     = 30'h1 << 23;
  localparam logic [29:0] M_PCIN    = 30'h1 << 22;
  localparam logic [29:0] M_MDRIN   = 30'h1 << 21;
  localparam logic [29:0] M_IRIN    = 30'h1 << 20;
  localparam logic [29:0] M_YIN     = 30'h1 << 19;
  localparam logic [29:0] M_GRA     = 30'h1 << 18;
  localparam logic [29:0] M_GRB     = 30'h1 << 17;
  localparam logic [29:0] M_GRC     = 30'h1 << 16;
  localparam logic [29:0] M_RIN     = 30'h1 << 15;
  localparam logic [29:0] M_ROUT    = 30'h1 << 14;
  localparam logic [29:0] M_INCPC   = 30'h1 << 13;
  localparam logic [29:0] M_READ    = 30'h1 << 12;
  localparam logic [29:0] M_ADD     = 30'h1 << 11;
  localparam logic [29:0] M_SUB     = 30'h1 << 10;
  localparam logic [29:0] M_AND     = 30'h1 << 9;
  localparam logic [29:0] M_OR      = 30'h1 << 8;
  localparam logic [29:0] M_SHR     = 30'h1 << 7;
  localparam logic [29:0] M_SHL     = 30'h1 << 6;
  localparam logic [29:0] M_ROR     = 30'h1 << 5;
  localparam logic [29:0] M_ROL     = 30'h1 << 4;
  localparam logic [29:0] M_NEG     = 30'h1 << 3;
  localparam logic [29:0] M_NOT     = 30'h1 << 2;
  localparam logic [29:0] M_WRITE   = 30'h1 << 1;
  localparam logic [29:0] M_RUN     = 30'h1;

  localparam logic [29:0] T0_MASK = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference microprogram for one instruction: per-step outputs and stall flag.
  logic [29:0] exp_q[$];
  bit          mem_q[$];

  function automatic logic [29:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd11: return M_ADD;
      5'd4:        return M_SUB;
      5'd5, 5'd12: return M_AND;
      5'd6, 5'd13: return M_OR;
      5'd7:        return M_SHR;
      5'd8:        return M_SHL;
      5'd9:        return M_ROR;
      5'd10:       return M_ROL;
      5'd16:       return M_NEG;
      5'd17:       return M_NOT;
      default:     return 30'h0;
    endcase
  endfunction

  task automatic push(input logic [29:0] m, input bit mem);
    exp_q.push_back(m | M_RUN);
    mem_q.push_back(mem);
  endtask

  task automatic build(input logic [4:0] op);
    exp_q.delete();
    mem_q.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 1'b1);
    push(M_MDROUT | M_IRIN, 1'b0);
    if (op >= 5'd3 && op <= 5'd13) begin
      push(M_GRB | M_ROUT | M_YIN, 1'b0);
      if (op <= 5'd10) push(M_GRC | M_ROUT | alu_of(op) | M_ZIN, 1'b0);
      else             push(M_COUT | alu_of(op) | M_ZIN, 1'b0);
      push(M_ZLOWOUT | M_GRA | M_RIN, 1'b0);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 1'b0);
      push(M_COUT | M_ADD | M_ZIN, 1'b0);
      if (op == 5'd1) push(M_ZLOWOUT | M_GRA | M_RIN, 1'b0);
      else begin
        push(M_ZLOWOUT | M_MARIN, 1'b0);
        if (op == 5'd0) begin
          push(M_READ | M_MDRIN, 1'b1);
          push(M_MDROUT | M_GRA | M_RIN, 1'b0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 1'b0);
          push(M_WRITE, 1'b1);
        end
      end
    end else if (op == 5'd16 || op == 5'd17) begin
      push(M_GRB | M_ROUT | alu_of(op) | M_ZIN, 1'b0);
      push(M_ZLOWOUT | M_GRA | M_RIN, 1'b0);
    end else begin
      push(30'h0, 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from T0. stall_force >= 0 fixes memory stall length;
  // abort_step >= 0 pulls clear low in that step and checks the abort.
  task automatic run_instr(input logic [31:0] ir, input int stall_force, input int abort_step);
    int stalls;
    logic [4:0] op;
    op = ir[31:27];
    IR = ir;
    build(op);
    for (int i = 0; i < exp_q.size(); i++) begin
      stalls = 0;
`ifdef CU_MEM_WAIT_EN
      if (mem_q[i]) stalls = (stall_force >= 0) ? stall_force : int'($urandom_range(0, 3));
`endif
      for (int s = 0; s <= stalls; s++) begin
`ifdef CU_MEM_WAIT_EN
        mem_ready = mem_q[i] ? (s == stalls) : 1'($urandom);
`else
        mem_ready = 1'($urandom);
`endif
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL step op=%b T%0d cycle %0d: got %b want %b", op, i, s, obs, exp_q[i]);
        end
        n_checks++;
        if ($countones(obs[11:2]) > 1) begin
          n_fail++;
          $display("FAIL alu_onehot op=%b T%0d: got strobes %b want at most one", op, i,
                   obs[11:2]);
        end
        if (i == abort_step) begin
          clear = 1'b0;
          tick();
          n_checks++;
          if (obs !== 30'h0) begin
            n_fail++;
            $display("FAIL abort_reset op=%b: got %b want 0", op, obs);
          end
          clear = 1'b1;
          tick();
          n_checks++;
          if (obs !== T0_MASK) begin
            n_fail++;
            $display("FAIL abort_to_t0: got %b want %b", obs, T0_MASK);
          end
          return;
        end
        tick();
      end
    end
    n_checks++;
    if (op == 5'b11001) begin
      if (obs !== 30'h0) begin
        n_fail++;
        $display("FAIL halt_entry: got %b want 0", obs);
      end
    end else if (obs !== T0_MASK) begin
      n_fail++;
      $display("FAIL end_at_t0 op=%b: got %b want %b", op, obs, T0_MASK);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (obs !== 30'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b want 0", obs);
      end
    end
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== T0_MASK) begin
      n_fail++;
      $display("FAIL reset_to_t0: got %b want %b", obs, T0_MASK);
    end
  endtask

  task automatic test_ldi();
    run_instr(32'h08800085, -1, -1);
  endtask

  task automatic test_add();
    run_instr(32'h19918000, -1, -1);
  endtask

  task automatic test_store_stall();
    run_instr({5'b00010, 27'h0123456}, 3, -1);
  endtask

  task automatic test_halt();
    run_instr({5'b11001, 27'h0}, -1, -1);
    repeat (5) begin
      mem_ready = 1'($urandom);
      tick();
      n_checks++;
      if (obs !== 30'h0) begin
        n_fail++;
        $display("FAIL halt_hold: got %b want 0", obs);
      end
    end
    clear = 1'b0;
    tick();
    n_checks++;
    if (obs !== 30'h0) begin
      n_fail++;
      $display("FAIL halt_reset: got %b want 0", obs);
    end
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs !== T0_MASK) begin
      n_fail++;
      $display("FAIL halt_restart: got %b want %b", obs, T0_MASK);
    end
  endtask

  task automatic test_reset_in_ld();
    run_instr({5'b00000, 27'($urandom)}, -1, 6);
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11001) op = 5'b11000;
      run_instr({op, 27'($urandom)}, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_store_stall();
    test_reset_in_ld();
    test_random();
    test_back_to_back_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic test_back_to_back_halt();
    test_halt();
    test_ldi();
  endtask

endmodule
